gate_truth_checker: RTL and testbench

Sequential self-test stage wrapped around the basic two-input gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and samples the block's 7-bit `y` result after a programmable settle time. It compares each sample against the golden truth table and reports pass/fail plus a per-vector mismatch mask. The block sits directly upstream of the gate block, supplying its inputs, and directly downstream of it, consuming its outputs.

---
 rtl/gate_check_pkg.sv | 37 +++
 rtl/gate_golden_lut.sv | 31 +++
 rtl/gate_truth_checker.sv | 144 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// ============================================================================
//  Module      : gate_check_pkg
//  Description : Shared constants for the gate truth-table self-test:
//                FSM state encoding, golden gate-block results for the four
//                input vectors, and bit positions of each gate within y.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package gate_check_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_REPORT = 2'd3;

   // Bit position of each gate within the 7-bit y bus
   localparam int Y_NOT  = 0;
   localparam int Y_AND  = 1;
   localparam int Y_OR   = 2;
   localparam int Y_NAND = 3;
   localparam int Y_NOR  = 4;
   localparam int Y_XOR  = 5;
   localparam int Y_XNOR = 6;

   // Golden results, one per {a,b} vector. The bus is declared [6:0] with
   // y[0] = NOT a, so each constant reads XNOR..NOT from left to right
   // (the reverse of the usual NOT-first truth-table notation).
   localparam logic [6:0] EXP_00 = 7'b1011001;  // NOT-first: 1001101
   localparam logic [6:0] EXP_01 = 7'b0101101;  // NOT-first: 1011010
   localparam logic [6:0] EXP_10 = 7'b0101100;  // NOT-first: 0011010
   localparam logic [6:0] EXP_11 = 7'b1000110;  // NOT-first: 0110001

endpackage

`default_nettype wire

// File: rtl/gate_golden_lut.sv
// ============================================================================
//  Module      : gate_golden_lut
//  Description : Combinational golden truth table for the two-input gate
//                block: maps the current {a,b} vector to the expected y.
//  Ports       : vec      in  2  input vector, vec = {a,b}
//                expected out 7  expected gate-block result, bit 0 = NOT a
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_golden_lut
   import gate_check_pkg::*;
(
   input  logic [1:0] vec,
   output logic [6:0] expected
);

   always_comb begin
      expected = EXP_00;
      case (vec)
         2'b00:   expected = EXP_00;
         2'b01:   expected = EXP_01;
         2'b10:   expected = EXP_10;
         2'b11:   expected = EXP_11;
         default: expected = EXP_00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/gate_truth_checker.sv
// ============================================================================
//  Module      : gate_truth_checker
//  Description : Sequential self-test for the two-input gate block. Walks
//                {a,b} through 00,01,10,11, waits SETTLE_CYCLES per vector,
//                samples y and compares it with the golden truth table.
//  Parameters  : SETTLE_CYCLES  cycles between driving a/b and sampling y
//                               (1..15, default 2)
//  Ports       : clk        in  1  clock, rising edge
//                rst        in  1  synchronous active-high reset
//                start      in  1  run request (accepted when not busy)
//                a, b       out 1  registered gate-block inputs
//                y          in  7  gate-block result, bit 0 = NOT a ..
//                                  bit 6 = XNOR
//                busy       out 1  run in progress
//                done       out 1  single-cycle end-of-run pulse
//                pass       out 1  all four vectors matched
//                fail_mask  out 4  bit v set when vector v = {a,b} failed
//                gate_fail  out 7  per-gate mismatch OR across vectors
//                                  (only with GATE_CHECK_DIAG_EN defined)
//  Macros      : GATE_CHECK_DIAG_EN  adds the gate_fail diagnostic port
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic [6:0] y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask
`ifdef GATE_CHECK_DIAG_EN
   ,
   output logic [6:0] gate_fail
`endif
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0] state;
   logic [1:0] vec;
   logic [3:0] settle_cnt;
   logic [6:0] expected;
   logic [6:0] mismatch;
   logic [3:0] mask_next;
   logic       start_accept;

   gate_golden_lut u_golden (
      .vec      (vec),
      .expected (expected)
   );

   assign mismatch = y ^ expected;

   // Mask including the vector being sampled this cycle, so the verdict
   // written on the final SAMPLE already covers vector 3.
   always_comb begin
      mask_next      = fail_mask;
      mask_next[vec] = |mismatch;
   end

   // The REPORT-exit edge doubles as the first IDLE sampling point, which
   // gives the back-to-back period of 4*(SETTLE_CYCLES+1)+1 cycles. A start
   // seen on the edge that enters REPORT is still in SAMPLE and is ignored.
   assign start_accept = start && ((state == ST_IDLE) || (state == ST_REPORT));

   assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
   assign done = (state == ST_REPORT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         vec        <= 2'd0;
         settle_cnt <= 4'd0;
         a          <= 1'b0;
         b          <= 1'b0;
         pass       <= 1'b0;
         fail_mask  <= 4'd0;
      end else begin
         case (state)
            ST_IDLE, ST_REPORT: begin
               if (start_accept) begin
                  state      <= ST_SETTLE;
                  vec        <= 2'd0;
                  settle_cnt <= 4'd0;
                  a          <= 1'b0;
                  b          <= 1'b0;
                  pass       <= 1'b0;
                  fail_mask  <= 4'd0;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end

            ST_SAMPLE: begin
               fail_mask <= mask_next;
               if (vec == 2'd3) begin
                  // a/b stay at 11 through REPORT
                  state <= ST_REPORT;
                  pass  <= ~|mask_next;
               end else begin
                  state      <= ST_SETTLE;
                  vec        <= vec + 2'd1;
                  {a, b}     <= vec + 2'd1;
                  settle_cnt <= 4'd0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef GATE_CHECK_DIAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         gate_fail <= 7'd0;
      end else if (start_accept) begin
         gate_fail <= 7'd0;
      end else if (state == ST_SAMPLE) begin
         gate_fail <= gate_fail | mismatch;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
// ============================================================================
//  Module      : tb_gate_truth_checker
//  Description : Self-checking bench for gate_truth_checker. A behavioural
//                gate block with injectable stuck-at-0 / stuck-at-1 / invert
//                faults drives y; expected verdicts come from plain boolean
//                gate definitions evaluated over all four vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_truth_checker;

   localparam int SC  = 2;
   localparam int RUN = 4 * (SC + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       a;
   logic       b;
   logic [6:0] y;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_mask;
`ifdef GATE_CHECK_DIAG_EN
   logic [6:0] gate_fail;
`endif

   logic [6:0] stuck0;
   logic [6:0] stuck1;
   logic [6:0] invert;

   logic [3:0] exp_mask;
   logic [6:0] exp_gf;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   // Ideal gate block: bit 0 NOT a, then AND, OR, NAND, NOR, XOR, XNOR.
   function automatic logic [6:0] gate_ref(input logic ia, input logic ib);
      return {~(ia ^ ib), ia ^ ib, ~(ia | ib), ~(ia & ib), ia | ib, ia & ib, ~ia};
   endfunction

   function automatic logic [6:0] faulty(input logic [6:0] good);
      return ((good & ~stuck0) | stuck1) ^ invert;
   endfunction

   assign y = faulty(gate_ref(a, b));

   gate_truth_checker #(.SETTLE_CYCLES(SC)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_mask (fail_mask)
`ifdef GATE_CHECK_DIAG_EN
      ,
      .gate_fail (gate_fail)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic predict();
      exp_mask = 4'd0;
      exp_gf   = 7'd0;
      for (int v = 0; v < 4; v++) begin
         logic [1:0] vv;
         logic [6:0] good;
         logic [6:0] seen;
         vv   = 2'(v);
         good = gate_ref(vv[1], vv[0]);
         seen = faulty(good);
         exp_mask[v] = (seen != good);
         exp_gf      = exp_gf | (seen ^ good);
      end
   endtask

   // One complete run; rp_a / rp_b are edge indices (relative to E0) at
   // which start is re-pulsed and must be ignored.
   task automatic run_one(input string name, input int rp_a, input int rp_b);
      int vexp;
      predict();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;            // after E0
      chk({name, " busy@E0"}, busy, 1);
      chk({name, " ab@E0"}, {a, b}, 0);
      chk({name, " pass_clr@E0"}, pass, 0);
      for (int k = 1; k <= RUN + 1; k++) begin
         start = (k == rp_a) || (k == rp_b);
         @(negedge clk);                       // after E_k
         start = 1'b0;
         vexp = (k / (SC + 1) > 3) ? 3 : k / (SC + 1);
         if (k < RUN) begin
            chk({name, " busy"}, busy, 1);
            chk({name, " done_early"}, done, 0);
            chk({name, " ab"}, {a, b}, vexp);
         end else if (k == RUN) begin
            chk({name, " done"}, done, 1);
            chk({name, " busy@report"}, busy, 0);
            chk({name, " ab@report"}, {a, b}, 3);
            chk({name, " pass"}, pass, (exp_mask == 4'd0));
            chk({name, " fail_mask"}, fail_mask, exp_mask);
`ifdef GATE_CHECK_DIAG_EN
            chk({name, " gate_fail"}, gate_fail, exp_gf);
`endif
         end else begin
            chk({name, " done_once"}, done, 0);
            chk({name, " idle_after"}, busy, 0);
            chk({name, " pass_hold"}, pass, (exp_mask == 4'd0));
            chk({name, " mask_hold"}, fail_mask, exp_mask);
         end
      end
   endtask

   initial begin
      int done_cyc[$];
      bit saw_done;

      rst    = 1'b1;
      start  = 1'b0;
      stuck0 = 7'd0;
      stuck1 = 7'd0;
      invert = 7'd0;
      repeat (2) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst pass", pass, 0);
      chk("rst fail_mask", fail_mask, 0);
      chk("rst ab", {a, b}, 0);
`ifdef GATE_CHECK_DIAG_EN
      chk("rst gate_fail", gate_fail, 0);
`endif
      rst = 1'b0;

      // Healthy gate block, start ignored mid-run and on the REPORT entry edge
      run_one("good", 4, RUN);

      // Reset while idle clears the held pass verdict
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("idle_rst pass", pass, 0);

      // AND stuck at 0, then XOR inverted
      stuck0 = 7'b0000010;
      run_one("and_sa0", -1, -1);
      stuck0 = 7'd0;
      invert = 7'b0100000;
      run_one("xor_inv", -1, -1);

      // Mid-run reset: vector 0 already failed (XOR inverted) before E5
      predict();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;            // after E0
      repeat (4) @(negedge clk);               // after E4
      chk("midrst mask_before", fail_mask, {3'd0, exp_mask[0]});
      rst = 1'b1;
      @(negedge clk);                          // after E5
      rst = 1'b0;
      chk("midrst busy", busy, 0);
      chk("midrst ab", {a, b}, 0);
      chk("midrst fail_mask", fail_mask, 0);
      chk("midrst pass", pass, 0);
      saw_done = 1'b0;
      for (int k = 0; k < RUN + 8; k++) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("midrst no_done", saw_done, 0);
      invert = 7'd0;

      // Back-to-back runs with start held high
      @(negedge clk); start = 1'b1;
      @(negedge clk);                          // after E0
      for (int c = 1; c <= 3 * (RUN + 1); c++) begin
         @(negedge clk);
         if (done) begin
            done_cyc.push_back(c);
            chk("b2b pass", pass, 1);
         end
      end
      start = 1'b0;
      chk("b2b count", done_cyc.size(), 3);
      if (done_cyc.size() == 3) begin
         chk("b2b done0", done_cyc[0], RUN);
         chk("b2b done1", done_cyc[1], 2 * RUN + 1);
         chk("b2b done2", done_cyc[2], 3 * RUN + 2);
      end
      repeat (RUN + 3) @(negedge clk);         // let the trailing run drain
      chk("b2b drained", busy, 0);

      // Randomised fault patterns
      for (int r = 0; r < 10; r++) begin
         stuck0 = 7'd0;
         stuck1 = 7'd0;
         invert = 7'd0;
         case ($urandom_range(0, 3))
            0: ;
            1: stuck0 = 7'(1 << $urandom_range(0, 6));
            2: stuck1 = 7'(1 << $urandom_range(0, 6));
            default: begin
               stuck0 = 7'($urandom);
               stuck1 = 7'($urandom) & ~stuck0;
               invert = 7'($urandom);
            end
         endcase
         run_one("rand", -1, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
